// File: rtl/icache_ctrl.sv
// Direct-mapped instruction-cache controller. Tags and valid bits live in
// local flops; line data lives in an external distributed-RAM line store with
// an asynchronous read port. Misses are refilled as a burst of beats that are
// assembled into one line and written in a single cycle.
`timescale 1ns/1ps
module icache_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128,
   parameter int DEPTH      = 128,
   parameter int BEAT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cpu_req_valid,
   input  logic [ADDR_WIDTH-1:0]      cpu_addr,
   output logic                       cpu_hit,
   output logic [BEAT_WIDTH-1:0]      cpu_rdata,
   input  logic                       flush,
   output logic                       mem_req_valid,
   input  logic                       mem_req_ready,
   output logic [ADDR_WIDTH-1:0]      mem_req_addr,
   input  logic                       mem_resp_valid,
   input  logic [BEAT_WIDTH-1:0]      mem_resp_data,
   output logic                       ram_we,
   output logic [$clog2(DEPTH)-1:0]   ram_a,
   output logic [LINE_WIDTH-1:0]      ram_di,
   input  logic [LINE_WIDTH-1:0]      ram_spo
);

   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int OFFW  = $clog2(LINE_WIDTH / 8);
   localparam int IDXW  = $clog2(DEPTH);
   localparam int TAGW  = ADDR_WIDTH - IDXW - OFFW;
   localparam int WOFF  = $clog2(BEAT_WIDTH / 8);
   localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

   state_t                          state_q, state_d;
   logic [DEPTH-1:0]                valid_q;
   logic [TAGW-1:0]                 tag_q [DEPTH];
   logic                            pending_q;
   logic [CNTW-1:0]                 cnt_q;
   logic [TAGW-1:0]                 miss_tag;
   logic [IDXW-1:0]                 miss_idx;
   logic [BEATS-1:0][BEAT_WIDTH-1:0] line_buf;
   logic [BEATS-1:0][BEAT_WIDTH-1:0] spo_words;

   // Fetch address fields; the byte-within-word bits are never used.
   logic [TAGW-1:0]      tag;
   logic [IDXW-1:0]      idx;
   logic [CNTW-1:0]      word;
   logic                 unused_byte_bits;
   logic                 lookup_hit;
   logic                 start_miss;

   assign tag              = cpu_addr[ADDR_WIDTH-1:IDXW+OFFW];
   assign idx              = cpu_addr[IDXW+OFFW-1:OFFW];
   assign word             = cpu_addr[OFFW-1:WOFF];
   assign unused_byte_bits = ^cpu_addr[WOFF-1:0];
   assign lookup_hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign start_miss       = (state_q == IDLE) && cpu_req_valid && !lookup_hit && !flush;

   // Data paths straight from state; the line buffer feeds the store directly.
   assign spo_words    = ram_spo;
   assign cpu_rdata    = spo_words[word];
   assign ram_di       = line_buf;
   assign mem_req_addr = {miss_tag, miss_idx, {OFFW{1'b0}}};

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: every clocked assignment is non-blocking so all flops see the
      // pre-edge values of each other regardless of statement order.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic for the refill sequence.
   always_comb begin
      // NOTE: default to holding state first so no path through the case
      // leaves state_d unassigned and infers a latch.
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_miss) state_d = REQ;
         REQ:     if (mem_req_ready) state_d = FILL;
         FILL:    if (mem_resp_valid && (cnt_q == LAST_BEAT)) state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: zero-cycle hit in IDLE, memory request and store write.
   always_comb begin
      cpu_hit       = (state_q == IDLE) && cpu_req_valid && lookup_hit && !flush;
      mem_req_valid = (state_q == REQ);
      ram_we        = (state_q == WRITE);
      ram_a         = (state_q == IDLE) ? idx : miss_idx;
   end

   // Valid bits, beat counter and flush-during-refill bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= '0;
         pending_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if ((state_q == REQ) && mem_req_ready)
            cnt_q <= '0;
         else if ((state_q == FILL) && mem_resp_valid)
            cnt_q <= cnt_q + 1'b1;

         if (state_q == WRITE) begin
            valid_q[miss_idx] <= !(pending_q || flush);
            pending_q         <= 1'b0;
         end else if (flush && (state_q != IDLE)) begin
            pending_q <= 1'b1;
         end

         // A flush always wins over the refill's own valid update.
         if (flush) valid_q <= '0;
      end
   end

   // Miss latch, beat assembly and tag update.
   always_ff @(posedge clk) begin
      // NOTE: tags, miss latch and line buffer are not reset; the valid bits
      // and the FSM decide when their contents mean anything.
      if (start_miss) begin
         miss_tag <= tag;
         miss_idx <= idx;
      end
      if ((state_q == FILL) && mem_resp_valid)
         line_buf[cnt_q] <= mem_resp_data;
      if (state_q == WRITE)
         tag_q[miss_idx] <= miss_tag;
   end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: a behavioural line store and memory
// driver around the controller, with refill requests and line-store writes
// checked against scoreboard queues filled as stimulus is issued.
`timescale 1ns/1ps
module tb_icache_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req_valid;
   logic [31:0]  cpu_addr;
   logic         cpu_hit;
   logic [31:0]  cpu_rdata;
   logic         flush;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [31:0]  mem_req_addr;
   logic         mem_resp_valid;
   logic [31:0]  mem_resp_data;
   logic         ram_we;
   logic [6:0]   ram_a;
   logic [127:0] ram_di;
   logic [127:0] ram_spo;

   typedef struct {
      logic [6:0]   idx;
      logic [127:0] data;
   } wr_t;

   logic [31:0] req_q [$];
   wr_t         wr_q  [$];

   int pass_cnt  = 0;
   int total_cnt = 0;
   int we_count  = 0;

   logic [127:0] line_ram [128];

   always #5 clk = ~clk;

   icache_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_req_valid  (cpu_req_valid),
      .cpu_addr       (cpu_addr),
      .cpu_hit        (cpu_hit),
      .cpu_rdata      (cpu_rdata),
      .flush          (flush),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .ram_we         (ram_we),
      .ram_a          (ram_a),
      .ram_di         (ram_di),
      .ram_spo        (ram_spo)
   );

   // Distributed-RAM line store: synchronous write, asynchronous read.
   initial for (int i = 0; i < 128; i++) line_ram[i] = '0;
   always @(posedge clk) if (ram_we === 1'b1) line_ram[ram_a] <= ram_di;
   assign ram_spo = line_ram[ram_a];

   // Scoreboard monitor: refill handshakes and line-store writes.
   always @(negedge clk) begin
      if (rst === 1'b0 && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
         total_cnt++;
         if (req_q.size() == 0) begin
            $display("FAIL unexpected_req got addr=%h expected no request", mem_req_addr);
         end else begin
            logic [31:0] exp_a;
            exp_a = req_q.pop_front();
            if (mem_req_addr !== exp_a)
               $display("FAIL req_addr got %h expected %h", mem_req_addr, exp_a);
            else pass_cnt++;
         end
      end
      if (ram_we === 1'b1) begin
         we_count++;
         total_cnt++;
         if (wr_q.size() == 0) begin
            $display("FAIL unexpected_write got idx=%h data=%h expected no write", ram_a, ram_di);
         end else begin
            wr_t exp_w;
            exp_w = wr_q.pop_front();
            if (ram_a !== exp_w.idx || ram_di !== exp_w.data)
               $display("FAIL line_write got idx=%h data=%h expected idx=%h data=%h",
                        ram_a, ram_di, exp_w.idx, exp_w.data);
            else pass_cnt++;
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Present a missing fetch, wait for the refill request, stall it, accept it.
   task automatic start_miss(input logic [31:0] addr, input int ready_delay, output bit ok);
      logic [31:0] first_addr;
      bit          stable;
      int          n;
      ok = 1'b0;
      req_q.push_back({addr[31:4], 4'h0});
      step();
      cpu_req_valid = 1'b1;
      cpu_addr      = addr;
      @(negedge clk);
      total_cnt++;
      if (cpu_hit !== 1'b0) $display("FAIL miss_detect addr=%h got cpu_hit=%b expected 0", addr, cpu_hit);
      else pass_cnt++;
      n = 0;
      while (mem_req_valid !== 1'b1 && n < 20) begin
         step();
         @(negedge clk);
         n++;
      end
      total_cnt++;
      if (mem_req_valid !== 1'b1) begin
         $display("FAIL req_timeout addr=%h got mem_req_valid=%b expected 1", addr, mem_req_valid);
         return;
      end
      pass_cnt++;
      first_addr = mem_req_addr;
      stable     = 1'b1;
      for (int d = 0; d < ready_delay; d++) begin
         step();
         // Stray beats and a wandering fetch address while the request waits.
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'hDEAD_0000 + d;
         cpu_addr       = addr ^ 32'h0000_5000;
         @(negedge clk);
         if (mem_req_valid !== 1'b1 || mem_req_addr !== first_addr) stable = 1'b0;
      end
      if (ready_delay > 0) begin
         total_cnt++;
         if (!stable) $display("FAIL req_stable got addr=%h now %h expected %h held", first_addr, mem_req_addr, {addr[31:4], 4'h0});
         else pass_cnt++;
      end
      step();
      mem_resp_valid = 1'b0;
      cpu_addr       = addr;
      mem_req_ready  = 1'b1;
      @(negedge clk);
      step();
      mem_req_ready = 1'b0;
      ok = 1'b1;
   endtask

   task automatic send_beats(input logic [127:0] line, input int nbeats, input int gap, input int flush_beat);
      for (int b = 0; b < nbeats; b++) begin
         if (b == flush_beat) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
         end
         if (b > 0) repeat (gap) step();
         mem_resp_valid = 1'b1;
         mem_resp_data  = line[b*32 +: 32];
         step();
         mem_resp_valid = 1'b0;
      end
   endtask

   // Complete refill: request, beats, write cycle, then the first IDLE cycle.
   task automatic refill(input logic [31:0] addr, input logic [127:0] line, input logic [31:0] exp_word,
                         input int ready_delay, input int gap, input int flush_beat, input bit expect_valid);
      bit  ok;
      wr_t w;
      w.idx  = addr[10:4];
      w.data = line;
      wr_q.push_back(w);
      start_miss(addr, ready_delay, ok);
      if (!ok) return;
      send_beats(line, 4, gap, flush_beat);
      @(negedge clk);
      total_cnt++;
      if (ram_we !== 1'b1) $display("FAIL write_cycle addr=%h got ram_we=%b expected 1", addr, ram_we);
      else pass_cnt++;
      step();
      @(negedge clk);
      total_cnt++;
      if (expect_valid) begin
         if (cpu_hit !== 1'b1 || cpu_rdata !== exp_word)
            $display("FAIL refill_hit addr=%h got hit=%b data=%h expected hit=1 data=%h", addr, cpu_hit, cpu_rdata, exp_word);
         else pass_cnt++;
      end else begin
         if (cpu_hit !== 1'b0)
            $display("FAIL refill_not_valid addr=%h got hit=%b expected 0", addr, cpu_hit);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset;
      rst            = 1'b1;
      cpu_req_valid  = 1'b1;
      cpu_addr       = 32'h0000_1004;
      flush          = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      repeat (3) step();
      @(negedge clk);
      total_cnt++;
      if (cpu_hit !== 1'b0) $display("FAIL reset_hit got %b expected 0", cpu_hit); else pass_cnt++;
      total_cnt++;
      if (mem_req_valid !== 1'b0) $display("FAIL reset_req got %b expected 0", mem_req_valid); else pass_cnt++;
      total_cnt++;
      if (ram_we !== 1'b0) $display("FAIL reset_we got %b expected 0", ram_we); else pass_cnt++;
      step();
      cpu_req_valid = 1'b0;
      rst           = 1'b0;
   endtask

   task automatic test_cold_miss;
      refill(32'h0000_1004, 128'h000000A3_000000A2_000000A1_000000A0, 32'h0000_00A1, 0, 0, -1, 1'b1);
   endtask

   task automatic test_hit_path;
      logic [31:0] addrs [3] = '{32'h0000_1000, 32'h0000_1008, 32'h0000_100C};
      logic [31:0] datas [3] = '{32'h0000_00A0, 32'h0000_00A2, 32'h0000_00A3};
      for (int i = 0; i < 3; i++) begin
         step();
         cpu_addr = addrs[i];
         @(negedge clk);
         total_cnt++;
         if (cpu_hit !== 1'b1 || cpu_rdata !== datas[i])
            $display("FAIL hit_path addr=%h got hit=%b data=%h expected hit=1 data=%h", addrs[i], cpu_hit, cpu_rdata, datas[i]);
         else pass_cnt++;
         total_cnt++;
         if (mem_req_valid !== 1'b0) $display("FAIL hit_no_req addr=%h got %b expected 0", addrs[i], mem_req_valid);
         else pass_cnt++;
      end
   endtask

   task automatic test_conflict;
      refill(32'h0000_1800, 128'h000000B3_000000B2_000000B1_000000B0, 32'h0000_00B0, 0, 0, -1, 1'b1);
      refill(32'h0000_1000, 128'h000000C3_000000C2_000000C1_000000C0, 32'h0000_00C0, 0, 0, -1, 1'b1);
   endtask

   task automatic test_back_to_back_stalls;
      int we_before;
      we_before = we_count;
      refill(32'h0000_2044, 128'h000000D3_000000D2_000000D1_000000D0, 32'h0000_00D1, 5, 2, -1, 1'b1);
      total_cnt++;
      if (we_count - we_before !== 1) $display("FAIL stall_single_write got %0d writes expected 1", we_count - we_before);
      else pass_cnt++;
   endtask

   task automatic test_flush_idle;
      step();
      cpu_req_valid = 1'b1;
      cpu_addr      = 32'h0000_1000;
      @(negedge clk);
      total_cnt++;
      if (cpu_hit !== 1'b1 || cpu_rdata !== 32'h0000_00C0)
         $display("FAIL pre_flush_hit got hit=%b data=%h expected hit=1 data=000000c0", cpu_hit, cpu_rdata);
      else pass_cnt++;
      step();
      flush = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (cpu_hit !== 1'b0) $display("FAIL flush_masks_hit got %b expected 0", cpu_hit); else pass_cnt++;
      step();
      flush = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (cpu_hit !== 1'b0) $display("FAIL post_flush_miss got %b expected 0", cpu_hit); else pass_cnt++;
      refill(32'h0000_1000, 128'h000000E3_000000E2_000000E1_000000E0, 32'h0000_00E0, 0, 0, -1, 1'b1);
   endtask

   task automatic test_flush_fill;
      refill(32'h0000_3000, 128'h000000F3_000000F2_000000F1_000000F0, 32'h0000_00F0, 0, 1, 2, 1'b0);
      refill(32'h0000_3000, 128'h00000093_00000092_00000091_00000090, 32'h0000_0090, 0, 0, -1, 1'b1);
   endtask

   task automatic test_reset_mid_fill;
      int we_before;
      bit ok;
      we_before = we_count;
      start_miss(32'h0000_4010, 0, ok);
      if (ok) send_beats(128'h00000053_00000052_00000051_00000050, 2, 0, -1);
      rst           = 1'b1;
      cpu_req_valid = 1'b0;
      cpu_addr      = 32'h0000_0050;
      @(negedge clk);
      total_cnt++;
      if (ram_a !== 7'h01) $display("FAIL pre_reset_ram_a got %h expected 01", ram_a); else pass_cnt++;
      step();
      @(negedge clk);
      total_cnt++;
      if (ram_a !== 7'h05) $display("FAIL reset_to_idle got ram_a=%h expected 05", ram_a); else pass_cnt++;
      total_cnt++;
      if (mem_req_valid !== 1'b0 || ram_we !== 1'b0)
         $display("FAIL reset_mid_fill_outputs got req=%b we=%b expected 0 0", mem_req_valid, ram_we);
      else pass_cnt++;
      step();
      rst           = 1'b0;
      cpu_req_valid = 1'b1;
      cpu_addr      = 32'h0000_3000;
      @(negedge clk);
      total_cnt++;
      if (cpu_hit !== 1'b0) $display("FAIL reset_clears_valid got hit=%b expected 0", cpu_hit); else pass_cnt++;
      total_cnt++;
      if (we_count !== we_before) $display("FAIL reset_no_write got %0d writes expected 0", we_count - we_before);
      else pass_cnt++;
      step();
      cpu_req_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit_path();
      test_conflict();
      test_back_to_back_stalls();
      test_flush_idle();
      test_flush_fill();
      test_reset_mid_fill();
      repeat (2) step();
      total_cnt++;
      if (req_q.size() != 0 || wr_q.size() != 0)
         $display("FAIL scoreboard_drain got %0d requests and %0d writes outstanding expected 0 0", req_q.size(), wr_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
